// File: rtl/if_stage_btb_fq.sv
// Instruction-fetch stage: direct-mapped BTB with 2-bit counters predicts the next
// fetch PC; fetched instructions are buffered in a small FIFO toward decode.
module if_stage_btb_fq #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     BTB_ENTRIES = 16,
    parameter int unsigned     FQ_DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic                      imem_req,
    output logic [XLEN-1:0]           imem_addr,
    input  logic [XLEN-1:0]           imem_rdata,
    input  logic                      redirect_valid,
    input  logic [XLEN-1:0]           redirect_pc,
    input  logic                      upd_valid,
    input  logic [XLEN-1:0]           upd_pc,
    input  logic                      upd_taken,
    input  logic [XLEN-1:0]           upd_target,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_pc,
    output logic [XLEN-1:0]           out_instr,
    output logic                      out_pred_taken,
    output logic [XLEN-1:0]           out_pred_target,
    output logic [$clog2(FQ_DEPTH):0] fq_count
);

    localparam int unsigned IW = $clog2(BTB_ENTRIES);
    localparam int unsigned TW = XLEN - IW - 2;
    localparam int unsigned PW = $clog2(FQ_DEPTH);
    localparam int unsigned CW = PW + 1;

    // ---------------- BTB storage ----------------
    logic [BTB_ENTRIES-1:0] btb_valid_q;
    logic [TW-1:0]          btb_tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]        btb_target_q [BTB_ENTRIES];
    logic [1:0]             btb_ctr_q    [BTB_ENTRIES];

    // ---------------- fetch state ----------------
    logic [XLEN-1:0] pc_q, pc_d;
    logic            inflight_q;
    logic [XLEN-1:0] inflight_pc_q;
    logic            inflight_taken_q;
    logic [XLEN-1:0] inflight_target_q;

    // ---------------- fetch queue ----------------
    logic [XLEN-1:0] fq_pc_q     [FQ_DEPTH];
    logic [XLEN-1:0] fq_instr_q  [FQ_DEPTH];
    logic            fq_taken_q  [FQ_DEPTH];
    logic [XLEN-1:0] fq_target_q [FQ_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;

    // ---------------- lookup at the fetch PC ----------------
    logic [IW-1:0]   f_idx;
    logic [TW-1:0]   f_tag;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    assign f_idx       = pc_q[IW+1:2];
    assign f_tag       = pc_q[XLEN-1:IW+2];
    assign pred_taken  = btb_valid_q[f_idx] && (btb_tag_q[f_idx] == f_tag) && btb_ctr_q[f_idx][1];
    assign pred_target = pred_taken ? btb_target_q[f_idx] : pc_q + XLEN'(4);

    // ---------------- update decode ----------------
    logic [IW-1:0] upd_idx;
    logic [TW-1:0] upd_tag;
    logic          upd_hit;
    logic          upd_we;
    logic [1:0]    upd_ctr_cur;
    logic [1:0]    upd_ctr_d;
    logic [1:0]    unused_upd_lsbs;

    assign upd_idx         = upd_pc[IW+1:2];
    assign upd_tag         = upd_pc[XLEN-1:IW+2];
    assign unused_upd_lsbs = upd_pc[1:0];
    assign upd_hit         = btb_valid_q[upd_idx] && (btb_tag_q[upd_idx] == upd_tag);
    assign upd_ctr_cur     = btb_ctr_q[upd_idx];
    // A not-taken miss leaves the table alone; a taken miss allocates weakly taken.
    assign upd_we          = upd_valid && (upd_hit || upd_taken);

    always_comb begin
        upd_ctr_d = 2'd2;
        if (upd_hit) begin
            if (upd_taken) begin
                upd_ctr_d = (upd_ctr_cur == 2'd3) ? 2'd3 : upd_ctr_cur + 2'd1;
            end else begin
                upd_ctr_d = (upd_ctr_cur == 2'd0) ? 2'd0 : upd_ctr_cur - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btb_valid_q <= '0;
        end else if (upd_we) begin
            btb_valid_q[upd_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (upd_we) begin
            btb_tag_q[upd_idx] <= upd_tag;
            btb_ctr_q[upd_idx] <= upd_ctr_d;
            if (upd_taken) begin
                btb_target_q[upd_idx] <= upd_target;
            end
        end
    end

    // ---------------- request / queue handshakes ----------------
    logic          push;
    logic          pop;
    logic [CW:0]   fetch_occ;

    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready && !redirect_valid;
    // A redirect squashes the response that arrives in the same cycle.
    assign push      = inflight_q && !redirect_valid;
    assign fetch_occ = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    assign imem_req  = rst_n && !redirect_valid && (fetch_occ < (CW+1)'(FQ_DEPTH));
    assign imem_addr = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (imem_req) begin
            pc_d = pred_target;
        end
    end

    always_comb begin
        count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        if (redirect_valid) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= imem_req;
            count_q    <= count_d;
            if (redirect_valid) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
            end
        end
    end

    // Payload registers carry no reset; validity is tracked by inflight_q/count_q.
    always_ff @(posedge clk) begin
        if (imem_req) begin
            inflight_pc_q     <= pc_q;
            inflight_taken_q  <= pred_taken;
            inflight_target_q <= pred_target;
        end
        if (push) begin
            fq_pc_q[wr_ptr_q]     <= inflight_pc_q;
            fq_instr_q[wr_ptr_q]  <= imem_rdata;
            fq_taken_q[wr_ptr_q]  <= inflight_taken_q;
            fq_target_q[wr_ptr_q] <= inflight_target_q;
        end
    end

    assign out_pc          = fq_pc_q[rd_ptr_q];
    assign out_instr       = fq_instr_q[rd_ptr_q];
    assign out_pred_taken  = fq_taken_q[rd_ptr_q];
    assign out_pred_target = fq_target_q[rd_ptr_q];
    assign fq_count        = count_q;

endmodule

// File: doc/if_stage_btb_fq.md
IF_STAGE_BTB_FQ -- requirements
Module: if_stage_btb_fq

Interface
REQ-001 Parameter XLEN, default 32: PC and instruction width.
REQ-002 Parameter BTB_ENTRIES, default 16: direct-mapped BTB entries, power of 2, >=2.
REQ-003 Parameter FQ_DEPTH, default 4: fetch-queue entries, power of 2, >=2.
REQ-004 Parameter RESET_PC, default 32'h0000_0000: fetch PC after reset.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 imem_req  output  1  fetch request to instruction memory this cycle.
REQ-008 imem_addr  output  XLEN  byte address of request.
REQ-009 imem_rdata  input  XLEN  instruction, valid exactly one cycle after an accepted imem_req.
REQ-010 redirect_valid  input  1  EX redirect (mispredict/jump).
REQ-011 redirect_pc  input  XLEN  redirect target.
REQ-012 upd_valid  input  1  BTB update from EX.
REQ-013 upd_pc  input  XLEN  PC of resolved branch.
REQ-014 upd_taken  input  1  actual outcome.
REQ-015 upd_target  input  XLEN  actual target.
REQ-016 out_valid  output  1  queue head valid to decode.
REQ-017 out_ready  input  1  decode accepts head.
REQ-018 out_pc / out_instr  output  XLEN each  head PC and instruction.
REQ-019 out_pred_taken  output  1  head predicted taken.
REQ-020 out_pred_target  output  XLEN  head predicted next PC (target if taken, else pc+4).
REQ-021 fq_count  output  log2(FQ_DEPTH)+1  current queue occupancy.

Function
REQ-022 BTB index = pc[log2(BTB_ENTRIES)+1:2]; tag = remaining upper bits; entry = valid, tag, target, 2-bit saturating counter.
REQ-023 Prediction at fetch PC: taken iff valid and tag match and counter>=2; purely combinational lookup.
REQ-024 imem_req=1 iff rst_n=1, redirect_valid=0, and fq_count + inflight(0/1) - pop_this_cycle < FQ_DEPTH; imem_addr = fetch PC.
REQ-025 On accepted request: fetch PC <= predicted target if taken else PC+4 (mod 2^XLEN); PC and prediction registered as in-flight tag.
REQ-026 Cycle after request: {pc, imem_rdata, prediction} pushed into queue; fetch-to-out_valid latency 2 cycles when queue empty.
REQ-027 Pop when out_valid && out_ready; push and pop in same cycle allowed at any occupancy; FIFO order preserved; pointers wrap modulo FQ_DEPTH.
REQ-028 Queue never overflows; out_valid=0 when empty; outputs hold stable while out_valid && !out_ready.
REQ-029 redirect_valid: queue cleared, in-flight response discarded next cycle, fetch PC <= redirect_pc, no request that cycle; fetching from redirect_pc starts next cycle; any same-cycle pop is void.
REQ-030 Update hit (valid, tag match): counter +1 sat at 3 if taken, -1 sat at 0 if not; target <= upd_target when taken.
REQ-031 Update miss: if upd_taken, allocate (overwrite) with tag, target, counter=2; if not taken, no change.
REQ-032 Update and lookup same entry same cycle: lookup sees pre-update value; redirect and update same cycle both take effect.

Reset
REQ-033 rst_n=0 asynchronously: fetch PC=RESET_PC, queue empty, fq_count=0, out_valid=0, in-flight cleared, all BTB valid bits 0, imem_req=0; BTB target/tag/counter not required reset.
REQ-034 First request at first rising edge with rst_n=1; reset mid-operation discards queue and in-flight fetch.

Verification
REQ-035 Reset release, out_ready=1, empty BTB -> imem_addr 0,4,8,...; out_pc=0 two cycles after first request, out_pred_taken=0, out_pred_target=4.
REQ-036 out_ready=0 -> exactly 4 requests (0x0..0xC), fq_count=4, imem_req=0; out_ready=1 one cycle -> pops 0x0, one new request 0x10.
REQ-037 upd_valid, upd_pc=0x20, upd_taken=1, upd_target=0x100 -> later fetch of 0x20 gives pred_taken=1, next imem_addr=0x100; two not-taken updates -> counter 0, prediction not taken.
REQ-038 redirect_valid, redirect_pc=0x40 with queue full and fetch in flight -> next cycle fq_count=0, out_valid=0, imem_addr=0x40, stale rdata not enqueued.
REQ-039 Update at upd_pc=0x20 and fetch of 0x20 in same cycle -> that fetch uses old prediction, next fetch of 0x20 uses new.
REQ-040 Alias: BTB_ENTRIES=16, entry for 0x20 then update 0x60 taken -> entry replaced; fetch of 0x20 predicts not taken.
